// File: rtl/bram_dp_be_if.sv
// Bus bundle for bram_dp_be: clear request/busy, write port and read port.
// The master modport belongs to whoever drives the RAM; the slave modport belongs to the RAM.
interface bram_dp_be_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic                  i_clear;
    logic                  o_busy;
    logic                  i_we;
    logic [NB-1:0]         i_be;
    logic [ADDR_WIDTH-1:0] i_waddr;
    logic [DATA_WIDTH-1:0] i_di;
    logic                  i_re;
    logic [ADDR_WIDTH-1:0] i_raddr;
    logic [DATA_WIDTH-1:0] o_dout;
    logic                  o_dvalid;

    modport master (
        output i_clear, i_we, i_be, i_waddr, i_di, i_re, i_raddr,
        input  o_busy, o_dout, o_dvalid
    );

    modport slave (
        input  i_clear, i_we, i_be, i_waddr, i_di, i_re, i_raddr,
        output o_busy, o_dout, o_dvalid
    );
endinterface

// File: rtl/bram_dp_be.sv
// Simple dual-port block RAM with byte-lane write enables, an optional output register,
// a read-valid strobe, configurable same-address collision behaviour and a zeroing engine.
module bram_dp_be #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned BYPASS     = 1
) (
    input logic               clk,
    input logic               i_rst_n,
    bram_dp_be_if.slave       bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  wr_en, rd_en, clr_wr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A clear request in IDLE wins over any access presented in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_wr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_clear) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end else begin
                    wr_en = bus.i_we;
                    rd_en = bus.i_re;
                end
            end
            StClear: begin
                clr_wr = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_busy = (state_q == StClear);

    // Storage has no reset; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (bus.i_be[k]) begin
                    mem[bus.i_waddr][8*k +: 8] <= bus.i_di[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[bus.i_raddr];
        if ((BYPASS != 0) && wr_en && (bus.i_waddr == bus.i_raddr)) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (bus.i_be[k]) begin
                    rd_word[8*k +: 8] = bus.i_di[8*k +: 8];
                end
            end
        end
    end

    // Data registers only load on a valid read so the output holds between reads.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid_q;
        logic [DATA_WIDTH-1:0] s2_data_q;

        always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign bus.o_dvalid = s2_valid_q;
        assign bus.o_dout   = s2_data_q;
    end else begin : g_no_out_reg
        assign bus.o_dvalid = s1_valid_q;
        assign bus.o_dout   = s1_data_q;
    end

endmodule

// File: tb/tb_bram_dp_be.sv
// Bench for bram_dp_be: two instances (latency 1 write-first, latency 2 read-first) share
// the same stimulus and are checked every cycle against a word-array memory model.
module tb_bram_dp_be;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned BYP0  = 1;
    localparam int unsigned BYP1  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          clr, we, re;
    logic [NB-1:0] be;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] di;

    bram_dp_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    bram_dp_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.i_clear = clr;
    assign bus0.i_we    = we;
    assign bus0.i_be    = be;
    assign bus0.i_waddr = wa;
    assign bus0.i_di    = di;
    assign bus0.i_re    = re;
    assign bus0.i_raddr = ra;
    assign bus1.i_clear = clr;
    assign bus1.i_we    = we;
    assign bus1.i_be    = be;
    assign bus1.i_waddr = wa;
    assign bus1.i_di    = di;
    assign bus1.i_re    = re;
    assign bus1.i_raddr = ra;

    bram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .BYPASS(BYP0)) dut0 (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus0.slave)
    );

    bram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .BYPASS(BYP1)) dut1 (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus1.slave)
    );

    // Reference model: plain word array, remaining clear cycles, and read results with due edges.
    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] mmem [DEPTH];
    int            busy_left;
    int            edge_n = 0;
    rd_t           q0[$];
    rd_t           q1[$];
    logic          exp_busy;
    logic          exp_v [2];
    logic [DW-1:0] exp_d [2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit run_chk = 1'b0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [NB-1:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < NB; k++) begin
            if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy_left = DEPTH;
        q0.delete();
        q1.delete();
        exp_busy = 1'b1;
        exp_v[0] = 1'b0;
        exp_v[1] = 1'b0;
        exp_d[0] = '0;
        exp_d[1] = '0;
    endtask

    // Drive one cycle, predict its effect, and publish the prediction just after the edge.
    task automatic cyc(input logic r, input logic c, input logic w, input logic [NB-1:0] b,
                       input logic [AW-1:0] a_w, input logic [DW-1:0] d, input logic rd,
                       input logic [AW-1:0] a_r);
        logic          nb;
        logic          nv [2];
        logic [DW-1:0] nd [2];
        logic [DW-1:0] old;
        rst_n = r; clr = c; we = w; be = b; wa = a_w; di = d; re = rd; ra = a_r;
        if (!r) begin
            model_reset();
            @(posedge clk);
            #1;
            edge_n++;
            return;
        end
        if (busy_left > 0) begin
            mmem[DEPTH - busy_left] = '0;
            busy_left--;
        end else if (c) begin
            busy_left = DEPTH;
        end else begin
            if (rd) begin
                old = mmem[a_r];
                q0.push_back('{edge_n,
                    ((BYP0 != 0) && w && (a_w == a_r)) ? merge(old, d, b) : old});
                q1.push_back('{edge_n + 1,
                    ((BYP1 != 0) && w && (a_w == a_r)) ? merge(old, d, b) : old});
            end
            if (w) mmem[a_w] = merge(mmem[a_w], d, b);
        end
        nb    = (busy_left > 0);
        nv[0] = 1'b0;
        nd[0] = exp_d[0];
        nv[1] = 1'b0;
        nd[1] = exp_d[1];
        if (q0.size() > 0 && q0[0].due == edge_n) begin
            nv[0] = 1'b1;
            nd[0] = q0[0].data;
            void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0].due == edge_n) begin
            nv[1] = 1'b1;
            nd[1] = q1[0].data;
            void'(q1.pop_front());
        end
        @(posedge clk);
        #1;
        edge_n++;
        exp_busy = nb;
        exp_v[0] = nv[0];
        exp_v[1] = nv[1];
        exp_d[0] = nd[0];
        exp_d[1] = nd[1];
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
        cyc(1'b1, 1'b0, 1'b1, b, a, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, a);
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            chk("busy0",   DW'(bus0.o_busy),   DW'(exp_busy));
            chk("busy1",   DW'(bus1.o_busy),   DW'(exp_busy));
            chk("dvalid0", DW'(bus0.o_dvalid), DW'(exp_v[0]));
            chk("dvalid1", DW'(bus1.o_dvalid), DW'(exp_v[1]));
            chk("dout0",   bus0.o_dout,        exp_d[0]);
            chk("dout1",   bus1.o_dout,        exp_d[1]);
        end
    end

    initial begin
        int n;
        int v0, v1;
        rst_n = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; be = '0; wa = '0; ra = '0; di = '0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = $urandom;
        model_reset();
        run_chk = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("t1_reset_dout0", bus0.o_dout, '0);
        chk("t1_reset_busy",  DW'(bus0.o_busy), DW'(1));

        // T1: busy length after release, then every address reads zero.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            n++;
            if (!bus0.o_busy) break;
        end
        chk("t1_busy_len", DW'(n), DW'(DEPTH));
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        idle();
        idle();

        // T2: byte-lane merge.
        wr(3'd2, 32'h1122_3344, 4'hF);
        wr(3'd2, 32'hAABB_CCDD, 4'b0101);
        rd(3'd2);
        chk("t2_dout0", bus0.o_dout, 32'h11BB_33DD);
        chk("t2_dv0",   DW'(bus0.o_dvalid), DW'(1));
        idle();
        chk("t2_dout1", bus1.o_dout, 32'h11BB_33DD);

        // T4: same-address collision on a zeroed word.
        cyc(1'b1, 1'b0, 1'b1, 4'b0011, 3'd5, 32'hCAFE_BABE, 1'b1, 3'd5);
        chk("t4_wfirst", bus0.o_dout, 32'h0000_BABE);
        idle();
        chk("t4_rfirst", bus1.o_dout, 32'h0000_0000);
        rd(3'd5);
        idle();
        chk("t4_after", bus1.o_dout, 32'h0000_BABE);

        // T3: eight back-to-back reads.
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'h1000_0000 + a, 4'hF);
        v0 = 0;
        v1 = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) rd(AW'(i));
            else idle();
            if (bus0.o_dvalid) v0++;
            if (bus1.o_dvalid) begin
                chk("t3_order1", bus1.o_dout, 32'h1000_0000 + v1);
                v1++;
            end
        end
        chk("t3_cnt0", DW'(v0), DW'(DEPTH));
        chk("t3_cnt1", DW'(v1), DW'(DEPTH));

        // T5: clear with a dropped write, re-pulse mid-clear.
        cyc(1'b1, 1'b1, 1'b1, 4'hF, 3'd1, 32'hFFFF_FFFF, 1'b0, '0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, (i == 3), 1'b0, '0, '0, '0, 1'b0, '0);
            n++;
            if (!bus0.o_busy) break;
        end
        chk("t5_busy_len", DW'(n), DW'(DEPTH));
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        idle();
        chk("t5_addr7", bus1.o_dout, '0);

        // T6: reset in the middle of a clear.
        wr(3'd3, 32'h5A5A_5A5A, 4'hF);
        rd(3'd3);
        idle();
        cyc(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        repeat (3) idle();
        cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("t6_rst_dout1", bus1.o_dout, '0);
        chk("t6_rst_busy",  DW'(bus1.o_busy), DW'(1));
        cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 4'hF, 3'd3, 32'hDEAD_BEEF, 1'b1, 3'd3);
            n++;
            if (!bus0.o_busy) break;
        end
        chk("t6_busy_len", DW'(n), DW'(DEPTH));
        rd(3'd3);
        chk("t6_nowrite", bus0.o_dout, '0);
        idle();

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 1) == 1), NB'($urandom), AW'($urandom), $urandom,
                ($urandom_range(0, 2) != 0), AW'($urandom));
        end
        repeat (3) idle();
        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
